muldiv_sequencer: RTL and testbench

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

---
 rtl/muldiv_sequencer.sv | 158 +++++++++++++++
 tb/tb_muldiv_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// Control sequencer for the MUL/DIV instruction path: fetches one instruction
// and steps the datapath strobes through T0..T6, trapping unknown opcodes.
module muldiv_sequencer (
  input  logic        clk,
  input  logic        clr,
  input  logic        start,
  input  logic        mem_ready,
  input  logic [31:0] ir,
  output logic        busy,
  output logic        done,
  output logic        illegal,
  output logic        PCout,
  output logic        MARin,
  output logic        IncPC,
  output logic        Zin,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        PCin,
  output logic        Read,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Yin,
  output logic        MUL,
  output logic        DIV,
  output logic        LOin,
  output logic        HIin,
  output logic        Rout,
  output logic [3:0]  Rsel
);

  typedef enum logic [3:0] {
    IDLE = 4'd0,
    T0   = 4'd1,
    T1   = 4'd2,
    T1W  = 4'd3,
    T2   = 4'd4,
    T3   = 4'd5,
    T4   = 4'd6,
    T5   = 4'd7,
    T6   = 4'd8,
    ERR  = 4'd9
  } state_t;

  localparam logic [4:0] OP_MUL = 5'b01111;
  localparam logic [4:0] OP_DIV = 5'b10000;

  state_t state_reg;
  state_t state_next;

  logic op_mul;
  logic op_div;
  logic unused_ir;

  assign op_mul    = (ir[31:27] == OP_MUL);
  assign op_div    = (ir[31:27] == OP_DIV);
  assign unused_ir = ^ir[18:0];

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Outputs depend only on the registered state (and stable ir), so they hold
  // steady for the full cycle and drop to zero as soon as clr forces IDLE.
  always_comb begin
    state_next = IDLE;
    busy       = 1'b1;
    done       = 1'b0;
    illegal    = 1'b0;
    PCout      = 1'b0;
    MARin      = 1'b0;
    IncPC      = 1'b0;
    Zin        = 1'b0;
    Zlowout    = 1'b0;
    Zhighout   = 1'b0;
    PCin       = 1'b0;
    Read       = 1'b0;
    MDRin      = 1'b0;
    MDRout     = 1'b0;
    IRin       = 1'b0;
    Yin        = 1'b0;
    MUL        = 1'b0;
    DIV        = 1'b0;
    LOin       = 1'b0;
    HIin       = 1'b0;
    Rout       = 1'b0;
    Rsel       = 4'd0;
    case (state_reg)
      IDLE: begin
        busy       = 1'b0;
        state_next = start ? T0 : IDLE;
      end
      T0: begin
        PCout      = 1'b1;
        MARin      = 1'b1;
        IncPC      = 1'b1;
        Zin        = 1'b1;
        state_next = T1;
      end
      T1: begin
        Zlowout    = 1'b1;
        PCin       = 1'b1;
        Read       = 1'b1;
        MDRin      = 1'b1;
        state_next = mem_ready ? T2 : T1W;
      end
      T1W: begin
        Read       = 1'b1;
        MDRin      = 1'b1;
        state_next = mem_ready ? T2 : T1W;
      end
      T2: begin
        MDRout     = 1'b1;
        IRin       = 1'b1;
        state_next = T3;
      end
      T3: begin
        Rout       = 1'b1;
        Yin        = 1'b1;
        Rsel       = ir[26:23];
        state_next = (op_mul || op_div) ? T4 : ERR;
      end
      T4: begin
        Rout       = 1'b1;
        Rsel       = ir[22:19];
        Zin        = 1'b1;
        MUL        = op_mul;
        DIV        = op_div;
        state_next = T5;
      end
      T5: begin
        Zlowout    = 1'b1;
        LOin       = 1'b1;
        state_next = T6;
      end
      T6: begin
        Zhighout   = 1'b1;
        HIin       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      ERR: begin
        illegal    = 1'b1;
        state_next = IDLE;
      end
      default: begin
        // Unused encodings: everything quiet, recover to IDLE.
        busy       = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed-vector bench for muldiv_sequencer: per-cycle strobe images are
// compared against hand-built expectations on the falling clock edge.
module tb_muldiv_sequencer;

  logic        clk;
  logic        clr;
  logic        start;
  logic        mem_ready;
  logic [31:0] ir;
  logic        busy, done, illegal;
  logic        PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin, Read;
  logic        MDRin, MDRout, IRin, Yin, MUL, DIV, LOin, HIin, Rout;
  logic [3:0]  Rsel;

  int vec_count  = 0;
  int miss_count = 0;

  muldiv_sequencer dut (
    .clk(clk), .clr(clr), .start(start), .mem_ready(mem_ready), .ir(ir),
    .busy(busy), .done(done), .illegal(illegal),
    .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Zin(Zin),
    .Zlowout(Zlowout), .Zhighout(Zhighout), .PCin(PCin), .Read(Read),
    .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin),
    .MUL(MUL), .DIV(DIV), .LOin(LOin), .HIin(HIin), .Rout(Rout), .Rsel(Rsel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bit positions of each strobe in the packed observation word.
  localparam logic [23:0] B_BUSY  = 24'h800000;
  localparam logic [23:0] B_DONE  = 24'h400000;
  localparam logic [23:0] B_ILL   = 24'h200000;
  localparam logic [23:0] B_PCO   = 24'h100000;
  localparam logic [23:0] B_MARI  = 24'h080000;
  localparam logic [23:0] B_INC   = 24'h040000;
  localparam logic [23:0] B_ZIN   = 24'h020000;
  localparam logic [23:0] B_ZLO   = 24'h010000;
  localparam logic [23:0] B_ZHI   = 24'h008000;
  localparam logic [23:0] B_PCI   = 24'h004000;
  localparam logic [23:0] B_READ  = 24'h002000;
  localparam logic [23:0] B_MDRI  = 24'h001000;
  localparam logic [23:0] B_MDRO  = 24'h000800;
  localparam logic [23:0] B_IRI   = 24'h000400;
  localparam logic [23:0] B_YIN   = 24'h000200;
  localparam logic [23:0] B_MUL   = 24'h000100;
  localparam logic [23:0] B_DIV   = 24'h000080;
  localparam logic [23:0] B_LOI   = 24'h000040;
  localparam logic [23:0] B_HII   = 24'h000020;
  localparam logic [23:0] B_ROUT  = 24'h000010;

  localparam logic [23:0] R_IDLE = 24'h0;
  localparam logic [23:0] R_T0   = B_BUSY | B_PCO | B_MARI | B_INC | B_ZIN;
  localparam logic [23:0] R_T1   = B_BUSY | B_ZLO | B_PCI | B_READ | B_MDRI;
  localparam logic [23:0] R_T1W  = B_BUSY | B_READ | B_MDRI;
  localparam logic [23:0] R_T2   = B_BUSY | B_MDRO | B_IRI;
  localparam logic [23:0] R_T5   = B_BUSY | B_ZLO | B_LOI;
  localparam logic [23:0] R_T6   = B_BUSY | B_ZHI | B_HII | B_DONE;
  localparam logic [23:0] R_ERR  = B_BUSY | B_ILL;

  // T3 reads ir[26:23], T4 reads ir[22:19]; both ir values below give 2 and 3.
  localparam logic [23:0] R_T3_23  = B_BUSY | B_ROUT | B_YIN | 24'd2;
  localparam logic [23:0] R_T4_DIV = B_BUSY | B_ROUT | B_ZIN | B_DIV | 24'd3;
  localparam logic [23:0] R_T4_MUL = B_BUSY | B_ROUT | B_ZIN | B_MUL | 24'd3;
  localparam logic [23:0] R_T3_ILL = B_BUSY | B_ROUT | B_YIN | 24'd1;

  // Each row: {start for next edge, mem_ready for next edge, expected outputs}.
  logic [25:0] row_q[$];

  function automatic logic [23:0] observe();
    return {busy, done, illegal, PCout, MARin, IncPC, Zin, Zlowout, Zhighout,
            PCin, Read, MDRin, MDRout, IRin, Yin, MUL, DIV, LOin, HIin, Rout,
            Rsel};
  endfunction

  task automatic check_vec(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    vec_count++;
    if (got !== exp) begin
      miss_count++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  function automatic logic [25:0] row(input logic s, input logic mr,
                                      input logic [23:0] e);
    return {s, mr, e};
  endfunction

  // Called at a falling edge in IDLE: raises start, then walks the row table.
  task automatic run_rows(input string name);
    int i;
    start     = 1'b1;
    mem_ready = 1'b1;
    i = 0;
    while (row_q.size() > 0) begin
      logic [25:0] r;
      r = row_q.pop_front();
      @(negedge clk);
      check_vec($sformatf("%s[%0d]", name, i), {8'h0, observe()},
                {8'h0, r[23:0]});
      start     = r[25];
      mem_ready = r[24];
      i++;
    end
  endtask

  task automatic load_plain(input logic [23:0] t3, input logic [23:0] t4);
    row_q.delete();
    row_q.push_back(row(0, 1, R_T0));
    row_q.push_back(row(0, 1, R_T1));
    row_q.push_back(row(0, 1, R_T2));
    row_q.push_back(row(0, 1, t3));
    row_q.push_back(row(0, 1, t4));
    row_q.push_back(row(0, 1, R_T5));
    row_q.push_back(row(0, 1, R_T6));
    row_q.push_back(row(0, 1, R_IDLE));
    row_q.push_back(row(0, 1, R_IDLE));
  endtask

  initial begin
    clr       = 1'b0;
    start     = 1'b0;
    mem_ready = 1'b1;
    ir        = 32'h0;

    #1;
    check_vec("reset_outputs", {8'h0, observe()}, 32'h0);
    repeat (2) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    check_vec("idle_after_release", {8'h0, observe()}, 32'h0);

    // DIV: done is the 7th row after the start edge.
    ir = 32'h81180000;
    load_plain(R_T3_23, R_T4_DIV);
    run_rows("div");

    // MUL: same sequence, MUL instead of DIV in T4.
    ir = 32'h79180000;
    load_plain(R_T3_23, R_T4_MUL);
    run_rows("mul");

    // Three wait cycles: mem_ready low when sampled in T1 and two T1W cycles.
    ir = 32'h81180000;
    row_q.delete();
    row_q.push_back(row(0, 1, R_T0));
    row_q.push_back(row(0, 0, R_T1));
    row_q.push_back(row(0, 0, R_T1W));
    row_q.push_back(row(0, 0, R_T1W));
    row_q.push_back(row(0, 1, R_T1W));
    row_q.push_back(row(0, 1, R_T2));
    row_q.push_back(row(0, 1, R_T3_23));
    row_q.push_back(row(0, 1, R_T4_DIV));
    row_q.push_back(row(0, 1, R_T5));
    row_q.push_back(row(0, 1, R_T6));
    row_q.push_back(row(0, 1, R_IDLE));
    run_rows("wait");

    // Illegal opcode 5'b00101.
    ir = 32'h28918000;
    row_q.delete();
    row_q.push_back(row(0, 1, R_T0));
    row_q.push_back(row(0, 1, R_T1));
    row_q.push_back(row(0, 1, R_T2));
    row_q.push_back(row(0, 1, R_T3_ILL));
    row_q.push_back(row(0, 1, R_ERR));
    row_q.push_back(row(0, 1, R_IDLE));
    run_rows("illegal");

    // Start held high: back-to-back with one IDLE cycle between T6 and T0.
    ir = 32'h79180000;
    row_q.delete();
    for (int k = 0; k < 2; k++) begin
      row_q.push_back(row(1, 1, R_T0));
      row_q.push_back(row(1, 1, R_T1));
      row_q.push_back(row(1, 1, R_T2));
      row_q.push_back(row(1, 1, R_T3_23));
      row_q.push_back(row(1, 1, R_T4_MUL));
      row_q.push_back(row(1, 1, R_T5));
      row_q.push_back(row(1, 1, R_T6));
      row_q.push_back(row(k == 0, 1, R_IDLE));
    end
    row_q.push_back(row(0, 1, R_IDLE));
    run_rows("b2b");

    // Asynchronous reset landing in T4 of a DIV.
    ir = 32'h81180000;
    row_q.delete();
    row_q.push_back(row(0, 1, R_T0));
    row_q.push_back(row(0, 1, R_T1));
    row_q.push_back(row(0, 1, R_T2));
    row_q.push_back(row(0, 1, R_T3_23));
    row_q.push_back(row(0, 1, R_T4_DIV));
    run_rows("pre_rst");
    #1;
    clr = 1'b0;
    #1;
    check_vec("rst_mid_t4", {8'h0, observe()}, 32'h0);
    @(negedge clk);
    clr = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_vec("idle_post_rst", {8'h0, observe()}, 32'h0);
    end
    load_plain(R_T3_23, R_T4_DIV);
    run_rows("div_after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
